// File: rtl/microbot_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// microbot_pkg : state codes, motor patterns and bit indices
// Rev 1.0
// ------------------------------------------------------------------
package microbot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FORWARD    = 3'd1,
    ST_TURN_RIGHT = 3'd2,
    ST_TURN_LEFT  = 3'd3,
    ST_REVERSE    = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  // motors = {A_fwd, A_rev, B_fwd, B_rev}
  localparam int c_a_fwd = 3;
  localparam int c_a_rev = 2;
  localparam int c_b_fwd = 1;
  localparam int c_b_rev = 0;

  // sensors = {front, left, right}
  localparam int c_sns_front = 2;
  localparam int c_sns_left  = 1;
  localparam int c_sns_right = 0;

  localparam logic [3:0] c_pat_stop       = 4'b0000;
  localparam logic [3:0] c_pat_forward    = 4'b1010;
  localparam logic [3:0] c_pat_reverse    = 4'b0101;
  localparam logic [3:0] c_pat_turn_right = 4'b1001;
  localparam logic [3:0] c_pat_turn_left  = 4'b0110;

  function automatic logic [3:0] motor_pattern(input state_t st);
    case (st)
      ST_FORWARD:    return c_pat_forward;
      ST_REVERSE:    return c_pat_reverse;
      ST_TURN_RIGHT: return c_pat_turn_right;
      ST_TURN_LEFT:  return c_pat_turn_left;
      default:       return c_pat_stop;
    endcase
  endfunction

  // Front is blocked: prefer right, then left, else back out.
  function automatic state_t obstacle_decision(input logic left, input logic right);
    if (!right)     return ST_TURN_RIGHT;
    else if (!left) return ST_TURN_LEFT;
    else            return ST_REVERSE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/microbot_nav_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// microbot_nav_ctrl_if : sensor, speed and motor-driver signal bundle
// Rev 1.0
// ------------------------------------------------------------------
interface microbot_nav_ctrl_if #(
  parameter int PWM_WIDTH = 8
);
  logic                 enable;
  logic [2:0]           sensors;
  logic [PWM_WIDTH-1:0] speed;
  logic [3:0]           motors;
  logic [2:0]           state_o;
  logic                 stuck;

  modport master (output enable, sensors, speed, input motors, state_o, stuck);
  modport slave  (input enable, sensors, speed, output motors, state_o, stuck);
endinterface
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// sensor_debounce : 2-flop synchroniser plus consecutive-sample filter
// Rev 1.0
// ------------------------------------------------------------------
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);
  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_filtered;
  logic [c_cnt_w-1:0] r_cnt;

  // Counter only runs while the synchronised value disagrees with the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_filtered <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filtered) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_filtered <= r_sync2;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign filtered = r_filtered;

endmodule
`default_nettype wire

// File: rtl/microbot_nav_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// microbot_nav_ctrl : obstacle-avoidance FSM with PWM and dead time
// Rev 1.0
// ------------------------------------------------------------------
module microbot_nav_ctrl
  import microbot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TURN_CYCLES     = 16,
  parameter int MAX_TURNS       = 4,
  parameter int REVERSE_CYCLES  = 32,
  parameter int STALL_LIMIT     = 3,
  parameter int DEAD_CYCLES     = 2,
  parameter int PWM_WIDTH       = 8
) (
  input  logic                clk,
  input  logic                reset,
  microbot_nav_ctrl_if.slave  bus
);
  localparam int c_timer_max = (TURN_CYCLES > REVERSE_CYCLES) ? TURN_CYCLES : REVERSE_CYCLES;
  localparam int c_timer_w   = (c_timer_max > 1) ? $clog2(c_timer_max) : 1;
  localparam int c_turn_w    = $clog2(MAX_TURNS + 1);
  localparam int c_rev_w     = $clog2(STALL_LIMIT + 1);
  localparam int c_dead_w    = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  localparam logic [c_timer_w-1:0] c_turn_last   = c_timer_w'(TURN_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_rev_last    = c_timer_w'(REVERSE_CYCLES - 1);
  localparam logic [c_turn_w-1:0]  c_turn_limit  = c_turn_w'(MAX_TURNS);
  localparam logic [c_rev_w-1:0]   c_stall_limit = c_rev_w'(STALL_LIMIT);
  localparam logic [c_dead_w-1:0]  c_dead_load   = c_dead_w'(DEAD_CYCLES);

  state_t                r_state;
  state_t                w_next;
  logic [c_timer_w-1:0]  r_timer;
  logic [c_turn_w-1:0]   r_turn_cnt;
  logic [c_turn_w-1:0]   w_turn_cnt_inc;
  logic [c_rev_w-1:0]    r_rev_cnt;
  logic [c_dead_w-1:0]   r_dead;
  logic [PWM_WIDTH-1:0]  r_pwm_cnt;
  logic [3:0]            r_motors;
  logic [2:0]            w_filt;
  logic                  w_front, w_left, w_right;
  logic                  w_in_turn, w_turn_done, w_rev_done;
  logic                  w_state_change, w_pwm_on;

  generate
    for (genvar i = 0; i < 3; i++) begin : g_debounce
      sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .raw      (bus.sensors[i]),
        .filtered (w_filt[i])
      );
    end
  endgenerate

  assign w_front        = w_filt[c_sns_front];
  assign w_left         = w_filt[c_sns_left];
  assign w_right        = w_filt[c_sns_right];
  assign w_in_turn      = (r_state == ST_TURN_RIGHT) || (r_state == ST_TURN_LEFT);
  assign w_turn_done    = (r_timer == c_turn_last);
  assign w_rev_done     = (r_timer == c_rev_last);
  assign w_turn_cnt_inc = r_turn_cnt + 1'b1;
  assign w_state_change = (w_next != r_state);
  assign w_pwm_on       = (r_pwm_cnt < bus.speed);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!bus.enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_next = w_front ? obstacle_decision(w_left, w_right) : ST_FORWARD;
        ST_FORWARD: if (w_front) w_next = obstacle_decision(w_left, w_right);
        ST_TURN_RIGHT, ST_TURN_LEFT: begin
          if (w_turn_done) begin
            if (!w_front)                        w_next = ST_FORWARD;
            else if (w_turn_cnt_inc == c_turn_limit) w_next = ST_REVERSE;
          end
        end
        // Stall check uses the count already bumped on entry.
        ST_REVERSE: begin
          if (r_rev_cnt == c_stall_limit) w_next = ST_FAULT;
          else if (w_rev_done)            w_next = (w_right && !w_left) ? ST_TURN_LEFT : ST_TURN_RIGHT;
        end
        ST_FAULT:   w_next = ST_FAULT;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      r_timer    <= '0;
      r_turn_cnt <= '0;
      r_rev_cnt  <= '0;
    end else begin
      if (w_state_change || (w_in_turn && w_turn_done) || ((r_state == ST_REVERSE) && w_rev_done))
        r_timer <= '0;
      else if (w_in_turn || (r_state == ST_REVERSE))
        r_timer <= r_timer + 1'b1;

      if (w_state_change)               r_turn_cnt <= '0;
      else if (w_in_turn && w_turn_done) r_turn_cnt <= w_turn_cnt_inc;

      if (w_state_change && (w_next == ST_FORWARD))      r_rev_cnt <= '0;
      else if (w_state_change && (w_next == ST_REVERSE)) r_rev_cnt <= r_rev_cnt + 1'b1;
    end
  end

  // Motor outputs follow the registered state one cycle later, blanked by dead time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_cnt <= '0;
      r_dead    <= '0;
      r_motors  <= c_pat_stop;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_state_change)  r_dead <= c_dead_load;
      else if (r_dead != '0) r_dead <= r_dead - 1'b1;
      r_motors <= ((r_dead == '0) && w_pwm_on) ? motor_pattern(r_state) : c_pat_stop;
    end
  end

  assign bus.motors  = r_motors;
  assign bus.state_o = r_state;
  assign bus.stuck   = (r_state == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_microbot_nav_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_microbot_nav_ctrl : directed checks of navigation, PWM and dead time
// Rev 1.0
// ------------------------------------------------------------------
module tb_microbot_nav_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt;

  logic [7:0] m_pwm;
  logic       m_on;

  microbot_nav_ctrl_if #(.PWM_WIDTH(8)) bus ();

  microbot_nav_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .TURN_CYCLES     (16),
    .MAX_TURNS       (4),
    .REVERSE_CYCLES  (32),
    .STALL_LIMIT     (3),
    .DEAD_CYCLES     (2),
    .PWM_WIDTH       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference PWM: m_on says whether the edge just taken had drive enabled.
  always @(posedge clk) begin
    if (reset) begin
      m_pwm <= 8'd0;
      m_on  <= 1'b0;
    end else begin
      m_on  <= (m_pwm < bus.speed);
      m_pwm <= m_pwm + 8'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_match(input int n, input logic [3:0] pat, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.motors == pat) c++;
    end
  endtask

  function automatic logic [3:0] exp_mot(input logic [3:0] pat);
    return m_on ? pat : 4'b0000;
  endfunction

  initial begin
    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.sensors = 3'b000;
    bus.speed   = 8'hFF;
    step(3);
    check("rst_state",  bus.state_o, 3'd0);
    check("rst_motors", bus.motors,  4'b0000);
    check("rst_stuck",  bus.stuck,   1'b0);

    // Clear path: FORWARD, then dead time before the pattern appears
    reset      = 1'b0;
    bus.enable = 1'b1;
    step(1); check("fwd_state",  bus.state_o, 3'd1);
    step(1); check("fwd_dead1",  bus.motors, 4'b0000);
    step(1); check("fwd_dead2",  bus.motors, 4'b0000);
    step(1); check("fwd_motors", bus.motors, exp_mot(4'b1010));

    count_match(256, 4'b1010, cnt); check("duty_ff", cnt, 255);
    bus.speed = 8'h80;
    count_match(256, 4'b1010, cnt); check("duty_80", cnt, 128);
    bus.speed = 8'hFF;

    // Front glitch of 3 samples is rejected
    bus.sensors = 3'b100; step(3); bus.sensors = 3'b000;
    step(10); check("glitch_state", bus.state_o, 3'd1);

    // 4-sample pulse: filtered at edge 6, TURN_RIGHT at edge 7
    bus.sensors = 3'b100; step(4); bus.sensors = 3'b000;
    step(2);  check("pulse_pre",   bus.state_o, 3'd1);
    step(1);  check("turn_right",  bus.state_o, 3'd2);
    step(3);  check("turn_motors", bus.motors, exp_mot(4'b1001));
    step(12); check("turn_hold",   bus.state_o, 3'd2);
    step(1);  check("turn_exit",   bus.state_o, 3'd1);

    // Boxed in: REVERSE / TURN cycles until the stall limit trips
    bus.sensors = 3'b111;
    step(6);  check("rev_pre",    bus.state_o, 3'd1);
    step(1);  check("rev_enter",  bus.state_o, 3'd4);
    step(3);  check("rev_motors", bus.motors, exp_mot(4'b0101));
    step(28); check("rev_hold",   bus.state_o, 3'd4);
    step(1);  check("rev_exit",   bus.state_o, 3'd2);
    step(63); check("turn_blk_hold", bus.state_o, 3'd2);
    step(1);  check("rev2_enter", bus.state_o, 3'd4);
    step(32); check("turn2_enter", bus.state_o, 3'd2);
    step(64); check("rev3_enter", bus.state_o, 3'd4);
    step(1);  check("fault_state", bus.state_o, 3'd5);
              check("fault_stuck", bus.stuck, 1'b1);
    step(3);  check("fault_motors", bus.motors, 4'b0000);
    step(5);  check("fault_hold", bus.state_o, 3'd5);

    // enable low leaves FAULT and aborts a REVERSE
    bus.enable = 1'b0;
    step(1); check("fault_exit", bus.state_o, 3'd0);
             check("unstuck",    bus.stuck, 1'b0);
    bus.enable = 1'b1;
    step(1); check("idle_to_rev", bus.state_o, 3'd4);
    step(5); check("rev_cnt_cleared", bus.state_o, 3'd4);
    bus.enable = 1'b0;
    step(1); check("en_low_state",  bus.state_o, 3'd0);
    step(1); check("en_low_motors", bus.motors, 4'b0000);

    // Right blocked, left free: TURN_LEFT, then reset mid-turn
    bus.sensors = 3'b101;
    step(8);
    bus.enable = 1'b1;
    step(1); check("turn_left", bus.state_o, 3'd3);
    step(5);
    reset = 1'b1;
    step(1); check("rst_mid_state",  bus.state_o, 3'd0);
             check("rst_mid_motors", bus.motors, 4'b0000);
             check("rst_mid_stuck",  bus.stuck, 1'b0);
    reset = 1'b0;
    step(1); check("post_rst_fwd", bus.state_o, 3'd1);

    // Zero speed: motors stay off in FORWARD and through the turn
    bus.speed = 8'h00;
    count_match(40, 4'b0000, cnt); check("speed0_motors", cnt, 40);
    check("speed0_state", bus.state_o, 3'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
